// File: rtl/spi_rx_deser.sv
// Receive-side byte engine for the Quad-SPI core: samples io_in on sample strobes,
// assembles MSB-first bytes in 1-bit or 4-bit mode and pushes them into the receive FIFO.
module spi_rx_deser #(
   parameter int LEN_W    = 9,
   parameter int MISO_IDX = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             quad_mode,
   input  logic [LEN_W-1:0] byte_len,
   input  logic             sample_en,
   input  logic [3:0]       io_in,
   input  logic             fifo_full,
   output logic             fifo_wr_en,
   output logic [7:0]       fifo_data,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic [LEN_W-1:0] bytes_rcvd
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] LAST  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             quad_q, quad_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [7:0]       sr_q, sr_d;
   logic [2:0]       bitCnt_q, bitCnt_d;
   logic [LEN_W-1:0] bytes_q, bytes_d;
   logic             push_q, push_d;
   logic [7:0]       data_q, data_d;
   logic             zeroDone_q, zeroDone_d;
   logic             ovf_q, ovf_d;

   logic [7:0]       shiftIn;
   logic [3:0]       cntSum;
   logic [LEN_W-1:0] bytesInc;

   assign shiftIn  = quad_q ? {sr_q[3:0], io_in} : {sr_q[6:0], io_in[MISO_IDX]};
   // The carry out of the 3-bit counter marks the sample that completes a byte.
   assign cntSum   = {1'b0, bitCnt_q} + (quad_q ? 4'd4 : 4'd1);
   assign bytesInc = bytes_q + LEN_W'(1);

   always_comb begin
      state_d    = state_q;
      quad_d     = quad_q;
      len_d      = len_q;
      sr_d       = sr_q;
      bitCnt_d   = bitCnt_q;
      bytes_d    = bytes_q;
      push_d     = 1'b0;
      data_d     = data_q;
      zeroDone_d = 1'b0;
      ovf_d      = ovf_q;
      if (abort) begin
         state_d  = IDLE;
         sr_d     = 8'd0;
         bitCnt_d = 3'd0;
      end else begin
         if (push_q && fifo_full) begin
            ovf_d = 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (start) begin
                  ovf_d = 1'b0;
                  if (byte_len != '0) begin
                     state_d  = SHIFT;
                     quad_d   = quad_mode;
                     len_d    = byte_len;
                     sr_d     = 8'd0;
                     bitCnt_d = 3'd0;
                     bytes_d  = '0;
                  end else begin
                     zeroDone_d = 1'b1;
                  end
               end
            end
            SHIFT: begin
               if (sample_en) begin
                  sr_d     = shiftIn;
                  bitCnt_d = cntSum[2:0];
                  if (cntSum[3]) begin
                     push_d  = 1'b1;
                     data_d  = shiftIn;
                     bytes_d = bytesInc;
                     if (bytesInc == len_q) begin
                        state_d = LAST;
                     end
                  end
               end
            end
            LAST:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         quad_q     <= 1'b0;
         len_q      <= '0;
         sr_q       <= 8'd0;
         bitCnt_q   <= 3'd0;
         bytes_q    <= '0;
         push_q     <= 1'b0;
         data_q     <= 8'd0;
         zeroDone_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         quad_q     <= quad_d;
         len_q      <= len_d;
         sr_q       <= sr_d;
         bitCnt_q   <= bitCnt_d;
         bytes_q    <= bytes_d;
         push_q     <= push_d;
         data_q     <= data_d;
         zeroDone_q <= zeroDone_d;
         ovf_q      <= ovf_d;
      end
   end

   // A pending byte is suppressed in the same cycle that abort or reset arrives.
   assign fifo_wr_en = push_q && !fifo_full && !abort && !reset;
   assign fifo_data  = data_q;
   assign busy       = (state_q != IDLE);
   assign done       = ((state_q == LAST) && !abort) || zeroDone_q;
   assign overflow   = ovf_q;
   assign bytes_rcvd = bytes_q;

endmodule
